// File: rtl/l2_arbiter.sv
// ---------------------------------------------------------------------------
// l2_arbiter
//
// Two-port wishbone arbiter between the split L1 caches and the unified L2.
// Instruction- and data-cache misses arrive on two wishbone slave ports. A
// registered grant FSM forwards one of them at a time to the wishbone master
// port that drives the L2 slave. Responses go back only to the granted port.
// Every other requester is answered with RTY until it receives its own ACK.
//
// Ports
//   clk, rst          single clock; asynchronous active-high reset
//   ic_*              I-cache slave port  (cyc, stb, we, adr, sel, dat_m in;
//                                          dat_s, ack, rty out)
//   dc_*              D-cache slave port  (same signal set as ic_*)
//   l2_*              L2 master port      (cyc, stb, we, adr, sel, dat_m out;
//                                          dat_s, ack, rty in)
//
// Lines are 128 bits with 16 byte-selects. ADR is a 12-bit line address.
// ---------------------------------------------------------------------------
module l2_arbiter (
    input  logic                clk,
    input  logic                rst,

    input  logic                ic_cyc,
    input  logic                ic_stb,
    input  logic                ic_we,
    input  logic [11:0]         ic_adr,
    input  logic [15:0]         ic_sel,
    input  logic [127:0]        ic_dat_m,
    output logic [127:0]        ic_dat_s,
    output logic                ic_ack,
    output logic                ic_rty,

    input  logic                dc_cyc,
    input  logic                dc_stb,
    input  logic                dc_we,
    input  logic [11:0]         dc_adr,
    input  logic [15:0]         dc_sel,
    input  logic [127:0]        dc_dat_m,
    output logic [127:0]        dc_dat_s,
    output logic                dc_ack,
    output logic                dc_rty,

    output logic                l2_cyc,
    output logic                l2_stb,
    output logic                l2_we,
    output logic [11:0]         l2_adr,
    output logic [15:0]         l2_sel,
    output logic [127:0]        l2_dat_m,
    input  logic [127:0]        l2_dat_s,
    input  logic                l2_ack,
    input  logic                l2_rty
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state;
    logic   last_d;     // 1 when the most recent completed grant went to D

    logic   req_i;
    logic   req_d;

    // L2 retry is never acted on: the caches keep STB/CYC up until they get
    // an ACK, which already amounts to a retry.
    logic   unused_l2_rty;

    assign unused_l2_rty = l2_rty;

    assign req_i = ic_stb & ic_cyc;
    assign req_d = dc_stb & dc_cyc;

    // Grant FSM. Every grant returns to IDLE on ACK or abort, so the L2 sees
    // at least one dead cycle between transactions. Only requests sampled in
    // IDLE can win a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i && req_d)
                        state <= last_d ? GNT_I : GNT_D;
                    else if (req_i)
                        state <= GNT_I;
                    else if (req_d)
                        state <= GNT_D;
                end
                GNT_I: begin
                    if (l2_ack) begin
                        state  <= IDLE;
                        last_d <= 1'b0;
                    end else if (!req_i) begin
                        state  <= IDLE;     // master abort, fairness untouched
                    end
                end
                GNT_D: begin
                    if (l2_ack) begin
                        state  <= IDLE;
                        last_d <= 1'b1;
                    end else if (!req_d) begin
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The master port mux is selected only by the registered state. The
    // request attributes are not latched, so the granted cache must hold them
    // steady for the whole grant. The async reset forces IDLE, which zeroes
    // the master port immediately.
    always_comb begin
        l2_cyc   = 1'b0;
        l2_stb   = 1'b0;
        l2_we    = 1'b0;
        l2_adr   = '0;
        l2_sel   = '0;
        l2_dat_m = '0;
        case (state)
            GNT_I: begin
                l2_cyc   = ic_cyc;
                l2_stb   = ic_stb;
                l2_we    = ic_we;
                l2_adr   = ic_adr;
                l2_sel   = ic_sel;
                l2_dat_m = ic_dat_m;
            end
            GNT_D: begin
                l2_cyc   = dc_cyc;
                l2_stb   = dc_stb;
                l2_we    = dc_we;
                l2_adr   = dc_adr;
                l2_sel   = dc_sel;
                l2_dat_m = dc_dat_m;
            end
            default: ;
        endcase
    end

    // Read data is broadcast. A port that has no ACK ignores it.
    assign ic_dat_s = l2_dat_s;
    assign dc_dat_s = l2_dat_s;

    // ACK passes straight through to the granted port in the same cycle.
    assign ic_ack = l2_ack & (state == GNT_I);
    assign dc_ack = l2_ack & (state == GNT_D);

    // A requester is retried every cycle until it sees its ACK. This applies
    // to the granted port as well. The retry is forced low during reset.
    assign ic_rty = req_i & ~ic_ack & ~rst;
    assign dc_rty = req_d & ~dc_ack & ~rst;

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-port wishbone arbiter between the split L1 caches and the unified L2. Instruction-cache and data-cache misses arrive on two wishbone slave ports. A registered grant FSM forwards exactly one of them to the single wishbone master port that drives the L2 slave. Responses are routed back only to the granted port, and every other requester is held off with RTY.

## Interface
- No parameters. Line width 128 bits, SEL 16 bits, ADR 12-bit line address (16-byte lines, 16-bit byte space), as fixed by the wishbone interface.
- `clk` input, 1: single clock. All state is updated on the rising edge.
- `rst` input, 1: reset, asynchronous and active-high.
- `ic` wishbone.slave: instruction-cache side, read-only in practice; WE is forwarded unmodified.
- `dc` wishbone.slave: data-cache side, reads and write-backs.
- `l2` wishbone.master: to the L2 wishbone slave (CYC, STB, WE, ADR, SEL, DAT_M out; DAT_S, ACK, RTY in).

## Operation
- State register `state` ∈ {IDLE, GNT_I, GNT_D}. Fairness bit `last_d` is 1 when the most recent completed grant was the D-cache.
- A port requests when `req_x = x.STB & x.CYC`.
- IDLE transitions:
  - Only `req_i`: go to GNT_I.
  - Only `req_d`: go to GNT_D.
  - Both: go to GNT_I if `last_d=1`, else GNT_D (alternate on contention).
  - Neither: stay in IDLE.
- GNT_x transitions:
  - `l2.ACK=1`: go to IDLE, set `last_d` (1 for GNT_D, 0 for GNT_I).
  - `req_x=0` (master abort): go to IDLE, `last_d` unchanged.
  - Otherwise stay.
- Master port in GNT_x: `l2.CYC/STB/WE/ADR/SEL/DAT_M` = port x values. In IDLE: CYC=STB=WE=0, ADR=0, SEL=0, DAT_M=0.
- Slave returns:
  - `x.DAT_S` = `l2.DAT_S` for both ports; the data is ignored without ACK.
  - `x.ACK` = `l2.ACK & (state==GNT_x)`.
  - `x.RTY` = `req_x & !x.ACK`. A port is always retried until it gets its ACK, whether or not it holds the grant.
- `l2.RTY` is ignored. Holding STB/CYC until ACK already implements retry.
- WE, ADR, SEL and DAT_M of the granted port must stay stable while granted. The arbiter does not latch them.

## Timing
- Reset: `state`=IDLE, `last_d`=0. As a result, a simultaneous first request grants D.
- All master outputs read 0 and all slave ACK/RTY read 0 while `rst`=1, irrespective of inputs. RTY is gated by reset.
- Reset mid-transaction: the grant is dropped immediately. `l2.CYC` falls in the same cycle `rst` rises. L2 must tolerate the abandoned request.
- Grant latency: request seen in IDLE at cycle 0; `l2.STB` asserted in cycle 1.
- ACK is combinational pass-through, in the same cycle as `l2.ACK`.
- The cycle after an ACK is always IDLE with `l2.CYC=0`. This guarantees at least one dead cycle between L2 transactions, which the L2 controller requires to return to its idle state.
- Back-to-back requests from the same port are therefore spaced at least 2 cycles apart at the master.
- When the other port is waiting, it is granted in the IDLE cycle after ACK. Its STB appears 2 cycles after the previous ACK.
- A request arriving in the same cycle as an ACK for the other port is considered in the following IDLE cycle, not before.
- Worst-case wait for a port: one full transaction of the other port plus 2 cycles. No starvation.

## Test plan
- Reset / idle:
  - Stimulus: hold `rst`=1 with `req_i=req_d=1`.
  - Required: `l2.CYC`=0, all ACK/RTY=0.
  - Stimulus: release reset.
  - Required: the next edge enters GNT_D; `l2.ADR` equals `dc.ADR` (e.g. 12'h0A5) in cycle 1.
- Single I read:
  - Stimulus: `ic` request at ADR 12'h123; L2 ACKs in cycle 5 with DAT_S=128'hDEAD…BEEF.
  - Required: `ic.RTY`=1 in cycles 0–4; `ic.ACK`=1 and data match in cycle 5; `l2.CYC`=0 in cycle 6.
- Contention alternation:
  - Stimulus: both ports request continuously.
  - Required: grant order D, I, D, I. `dc.RTY` stays 1 during the I grant. Each `l2.STB` rise is exactly 2 cycles after the preceding ACK.
- D write-back:
  - Stimulus: `dc` WE=1, SEL=16'hFFFF, DAT_M=128'h0123…CDEF.
  - Required: `l2.WE`=1 and `l2.DAT_M` equal to those values throughout the grant; `ic.ACK` never asserted.
- Abort:
  - Stimulus: the granted I port drops CYC in cycle 3, before any ACK.
  - Required: IDLE at the next edge; `last_d` unchanged; a pending D request is granted the following cycle.
- Async reset mid-grant:
  - Stimulus: assert `rst` between edges during GNT_D.
  - Required: `l2.CYC`=0 immediately; after release, arbitration restarts with `last_d`=0.
